line_clear_ctrl: RTL and testbench
==================================

Name: line_clear_ctrl

Overview:
- Sequences the Tetris board matrix memory to remove completed rows after a piece locks.
- Scans the board from the bottom row (size_p-1) up to row 0 and compacts the surviving rows downward.
- Zero-fills the vacated top rows and reports how many lines were cleared.
- Sits between the game FSM (start/done) and the memory's row read port and row write port.

Parameters:
- word_width_p, 16, row width in cells; one bit per cell, 1 = occupied.
- size_p, 16, number of rows; row addresses are 0 (top) to size_p-1 (bottom).
- addr_width_lp, $clog2(size_p), row address width (localparam).
- cnt_width_lp, $clog2(size_p+1), width of the cleared-lines count (localparam).

Ports:
- clk_li  in  1  clock.
- reset_li  in  1  synchronous, active-high reset.
- start_li  in  1  one-cycle request to run a clear pass; ignored while busy_lo=1.
- busy_lo  out  1  high from the cycle after an accepted start until done_lo.
- done_lo  out  1  one-cycle pulse when the pass completes.
- lines_cleared_lo  out  cnt_width_lp  full rows removed by the last pass.
- mem_ready_li  in  1  memory is_ready; gates every read issue and every write acceptance.
- rd_addr_lo  out  addr_width_lp  row read address.
- rd_v_lo  out  1  row read valid.
- rd_data_li  in  word_width_p  row data, valid the cycle after an issued read.
- wr_addr_lo  out  addr_width_lp  row write address.
- wr_data_lo  out  word_width_p  row write data.
- wr_v_lo  out  1  row write valid; a write is accepted on any cycle with wr_v_lo=1 and mem_ready_li=1.

Behaviour:
- Reset: state=IDLE; busy_lo, done_lo, rd_v_lo, wr_v_lo=0; lines_cleared_lo=0; src and dst pointers=size_p-1. Reset mid-pass aborts immediately; no further writes are issued.
- Internal pointers src (row being read) and dst (next row to write) are addr_width_lp+1 bits wide, so decrementing below 0 is representable.
- IDLE: on start_li=1 → load src=dst=size_p-1, clear the count to 0, go to READ. lines_cleared_lo holds its old value until this start.
- READ: rd_addr_lo=src, rd_v_lo=rd_v. rd_v equals mem_ready_li; the read is issued only when mem_ready_li=1. Issued read → go to EVAL; otherwise stay in READ.
- EVAL: latch rd_data_li.
  - If the row is full (all ones): increment the count.
  - Else if src==dst: no write needed; decrement dst.
  - Else: go to WRITE with the data latched.
  - In the full and src==dst cases: if src==0 → go to FILL when count>0, else go to DONE; otherwise decrement src and go to READ.
- WRITE: wr_v_lo=1, wr_addr_lo=dst, wr_data_lo=the latched row, held stable until accepted. On acceptance: decrement dst; then if src==0 → go to FILL; else decrement src and go to READ.
- FILL: wr_v_lo=1, wr_addr_lo=dst, wr_data_lo=0. On each acceptance decrement dst. When the accepted write has dst==0 → go to DONE. Exactly count rows are zeroed.
- DONE: done_lo=1 for one cycle; lines_cleared_lo=count; busy_lo drops in the same cycle; then go to IDLE.
- rd_v_lo and wr_v_lo are never high in the same cycle.
- Latency with mem_ready_li held at 1:
  - 2 cycles per row (READ+EVAL).
  - +1 cycle per shifted row (WRITE).
  - +1 cycle per zero-filled row.
  - +1 cycle for DONE.
- start_li arriving while busy or in DONE is dropped, not queued.

Test Plan:
- Empty board, mem_ready=1, start → 0 writes, done_lo asserts exactly 33 cycles after start, lines_cleared_lo=0.
- Row 15=16'hFFFF, row 14=16'h0001, others 0 → row 15 written 16'h0001, row 0 written 0, each row 0..14 written exactly once overall, lines_cleared_lo=1.
- Rows 12..15 all 16'hFFFF, row 11=16'h00F0 → row 15 gets 16'h00F0, rows 0..3 zero-filled, lines_cleared_lo=4.
- Non-adjacent full rows 15 and 13, row 14=16'hAAAA, row 12=16'h5555 → row 15=AAAA, row 14=5555, rows 0..1 zero, count=2.
- mem_ready_li low for 5 cycles during WRITE → wr_addr_lo/wr_data_lo held stable, no duplicate write, same final board as the ready=1 run.
- reset_li mid-FILL → next cycle all valids 0 and count 0; start_li pulsed while busy → ignored, only one done_lo pulse.

Source files
------------

// File: rtl/line_clear_ctrl.sv
// Line-clear sequencer: scans the board bottom-up, compacts the surviving rows
// downward, zero-fills the vacated top rows and reports the cleared-line count.
//
// state | meaning
// IDLE  | waiting for start_li
// READ  | issue row read at src (only when mem_ready_li)
// EVAL  | inspect returned row: count it, keep it in place, or move it
// WRITE | write latched row to dst, held until accepted
// FILL  | zero rows dst down to 0
// DONE  | one-cycle completion pulse
module line_clear_ctrl #(
  parameter int word_width_p = 16,
  parameter int size_p = 16,
  localparam int addr_width_lp = $clog2(size_p),
  localparam int cnt_width_lp = $clog2(size_p + 1)
) (
  input  logic                     clk_li,
  input  logic                     reset_li,
  input  logic                     start_li,
  output logic                     busy_lo,
  output logic                     done_lo,
  output logic [cnt_width_lp-1:0]  lines_cleared_lo,
  input  logic                     mem_ready_li,
  output logic [addr_width_lp-1:0] rd_addr_lo,
  output logic                     rd_v_lo,
  input  logic [word_width_p-1:0]  rd_data_li,
  output logic [addr_width_lp-1:0] wr_addr_lo,
  output logic [word_width_p-1:0]  wr_data_lo,
  output logic                     wr_v_lo
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_EVAL, S_WRITE, S_FILL, S_DONE
  } state_e;

  // Pointers carry one extra bit so that stepping below row 0 stays representable.
  localparam logic [addr_width_lp:0] last_row_lp = (addr_width_lp + 1)'(size_p - 1);
  localparam logic [addr_width_lp:0] ptr_one_lp  = (addr_width_lp + 1)'(1);
  localparam logic [cnt_width_lp-1:0] cnt_one_lp = cnt_width_lp'(1);

  state_e                    state_q, state_d;
  logic [addr_width_lp:0]    src_q, src_d;
  logic [addr_width_lp:0]    dst_q, dst_d;
  logic [cnt_width_lp-1:0]   cnt_q, cnt_d;
  logic [word_width_p-1:0]   row_q, row_d;
  logic                      advance;

  always_ff @(posedge clk_li) begin
    if (reset_li) begin
      state_q <= S_IDLE;
      src_q   <= last_row_lp;
      dst_q   <= last_row_lp;
      cnt_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    cnt_d      = cnt_q;
    row_d      = row_q;
    advance    = 1'b0;
    rd_v_lo    = 1'b0;
    wr_v_lo    = 1'b0;
    wr_data_lo = '0;
    done_lo    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_li) begin
          src_d   = last_row_lp;
          dst_d   = last_row_lp;
          cnt_d   = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        rd_v_lo = mem_ready_li;
        if (mem_ready_li) state_d = S_EVAL;
      end
      S_EVAL: begin
        row_d = rd_data_li;
        if (&rd_data_li) begin
          cnt_d   = cnt_q + cnt_one_lp;
          advance = 1'b1;
        end else if (src_q == dst_q) begin
          dst_d   = dst_q - ptr_one_lp;
          advance = 1'b1;
        end else begin
          state_d = S_WRITE;
        end
        if (advance) begin
          if (src_q == '0) begin
            state_d = (cnt_d != '0) ? S_FILL : S_DONE;
          end else begin
            src_d   = src_q - ptr_one_lp;
            state_d = S_READ;
          end
        end
      end
      S_WRITE: begin
        wr_v_lo    = 1'b1;
        wr_data_lo = row_q;
        if (mem_ready_li) begin
          dst_d = dst_q - ptr_one_lp;
          if (src_q == '0) begin
            state_d = S_FILL;
          end else begin
            src_d   = src_q - ptr_one_lp;
            state_d = S_READ;
          end
        end
      end
      S_FILL: begin
        wr_v_lo = 1'b1;
        if (mem_ready_li) begin
          dst_d = dst_q - ptr_one_lp;
          if (dst_q == '0) state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_lo = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_addr_lo       = src_q[addr_width_lp-1:0];
  assign wr_addr_lo       = dst_q[addr_width_lp-1:0];
  assign lines_cleared_lo = cnt_q;
  assign busy_lo          = (state_q == S_READ) || (state_q == S_EVAL) ||
                            (state_q == S_WRITE) || (state_q == S_FILL);

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Bench for line_clear_ctrl: board memory model plus a row-list reference of
// the expected compacted board, write counts and pass latency.
module tb_line_clear_ctrl;
  localparam int W = 16;
  localparam int N = 16;

  logic          clk_li = 1'b0;
  logic          reset_li = 1'b1;
  logic          start_li = 1'b0;
  logic          busy_lo, done_lo;
  logic [4:0]    lines_cleared_lo;
  logic          mem_ready_li = 1'b1;
  logic [3:0]    rd_addr_lo, wr_addr_lo;
  logic          rd_v_lo, wr_v_lo;
  logic [W-1:0]  rd_data_li = '0;
  logic [W-1:0]  wr_data_lo;

  line_clear_ctrl #(.word_width_p(W), .size_p(N)) dut (
    .clk_li(clk_li), .reset_li(reset_li), .start_li(start_li),
    .busy_lo(busy_lo), .done_lo(done_lo), .lines_cleared_lo(lines_cleared_lo),
    .mem_ready_li(mem_ready_li), .rd_addr_lo(rd_addr_lo), .rd_v_lo(rd_v_lo),
    .rd_data_li(rd_data_li), .wr_addr_lo(wr_addr_lo), .wr_data_lo(wr_data_lo),
    .wr_v_lo(wr_v_lo)
  );

  always #5 clk_li = ~clk_li;

  logic [W-1:0] mem [N];
  int           wr_cnt [N];
  int           overlap;
  int           done_pulses;

  logic [W-1:0] exp_mem [N];
  int           exp_wr [N];
  int           exp_cnt;
  int           exp_shift;

  int n_checks = 0;
  int n_errors = 0;

  always @(posedge clk_li) begin
    if (rd_v_lo && mem_ready_li) rd_data_li <= mem[rd_addr_lo];
    if (wr_v_lo && mem_ready_li) begin
      mem[wr_addr_lo]    <= wr_data_lo;
      wr_cnt[wr_addr_lo] <= wr_cnt[wr_addr_lo] + 1;
    end
    if (rd_v_lo && wr_v_lo) overlap <= overlap + 1;
    if (done_lo) done_pulses <= done_pulses + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reference: surviving rows keep bottom-up order and stack from row N-1;
  // the count of full rows becomes zero rows at the top.
  task automatic build_model();
    logic [W-1:0] keep[$];
    keep = {};
    exp_cnt = 0;
    exp_shift = 0;
    for (int i = 0; i < N; i++) exp_wr[i] = 0;
    for (int r = N - 1; r >= 0; r--) begin
      if (mem[r] == {W{1'b1}}) exp_cnt++;
      else begin
        int dest;
        dest = N - 1 - keep.size();
        if (dest != r) begin
          exp_wr[dest]++;
          exp_shift++;
        end
        keep.push_back(mem[r]);
      end
    end
    for (int i = 0; i < N; i++) exp_mem[i] = '0;
    for (int k = 0; k < keep.size(); k++) exp_mem[N - 1 - k] = keep[k];
    for (int r = 0; r < exp_cnt; r++) exp_wr[r]++;
  endtask

  function automatic int total_writes();
    int s = 0;
    for (int i = 0; i < N; i++) s += wr_cnt[i];
    return s;
  endfunction

  task automatic run_pass(input bit rnd_rdy, input bit stall, input bit poke);
    int cyc;
    bit stalled;
    logic [3:0] sa;
    logic [W-1:0] sd;
    build_model();
    for (int i = 0; i < N; i++) wr_cnt[i] = 0;
    overlap = 0;
    done_pulses = 0;
    stalled = 1'b0;
    mem_ready_li = 1'b1;
    start_li = 1'b1;
    @(posedge clk_li); #1;
    start_li = 1'b0;
    cyc = 1;
    while (!done_lo && cyc < 3000) begin
      if (stall && !stalled && wr_v_lo && wr_data_lo != '0) begin
        stalled = 1'b1;
        sa = wr_addr_lo;
        sd = wr_data_lo;
        mem_ready_li = 1'b0;
        repeat (5) begin
          @(posedge clk_li); #1;
          cyc++;
          chk("stall_wr_v", wr_v_lo, 1);
          chk("stall_addr", wr_addr_lo, sa);
          chk("stall_data", wr_data_lo, sd);
        end
        chk("stall_no_write", wr_cnt[sa], 0);
        mem_ready_li = 1'b1;
      end else begin
        mem_ready_li = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      start_li = poke && (cyc % 7 == 3);
      @(posedge clk_li); #1;
      cyc++;
    end
    start_li = 1'b0;
    chk("done_seen", done_lo, 1);
    if (!rnd_rdy && !stall) chk("latency", cyc, 2 * N + exp_shift + exp_cnt + 1);
    chk("lines_cleared", lines_cleared_lo, exp_cnt);
    chk("busy_in_done", busy_lo, 0);
    mem_ready_li = 1'b1;
    repeat (3) begin @(posedge clk_li); #1; end
    chk("busy_after", busy_lo, 0);
    chk("done_pulses", done_pulses, 1);
    chk("rd_wr_overlap", overlap, 0);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("row%0d", i), mem[i], exp_mem[i]);
      chk($sformatf("wr_cnt%0d", i), wr_cnt[i], exp_wr[i]);
    end
  endtask

  task automatic clear_board();
    for (int i = 0; i < N; i++) mem[i] = '0;
  endtask

  initial begin
    int snap, guard;
    clear_board();
    for (int i = 0; i < N; i++) wr_cnt[i] = 0;
    overlap = 0;
    done_pulses = 0;
    repeat (3) @(posedge clk_li);
    #1 reset_li = 1'b0;
    chk("rst_busy", busy_lo, 0);
    chk("rst_done", done_lo, 0);
    chk("rst_rd_v", rd_v_lo, 0);
    chk("rst_wr_v", wr_v_lo, 0);
    chk("rst_lines", lines_cleared_lo, 0);

    // empty board
    clear_board();
    run_pass(0, 0, 0);

    // single full row at the bottom
    clear_board();
    mem[15] = 16'hFFFF; mem[14] = 16'h0001;
    run_pass(0, 0, 0);

    // four stacked full rows
    clear_board();
    for (int i = 12; i < 16; i++) mem[i] = 16'hFFFF;
    mem[11] = 16'h00F0;
    run_pass(0, 0, 0);

    // non-adjacent full rows, ready held at 1
    clear_board();
    mem[15] = 16'hFFFF; mem[14] = 16'hAAAA; mem[13] = 16'hFFFF; mem[12] = 16'h5555;
    run_pass(0, 0, 0);

    // same board with a 5-cycle stall on the first shifted write
    clear_board();
    mem[15] = 16'hFFFF; mem[14] = 16'hAAAA; mem[13] = 16'hFFFF; mem[12] = 16'h5555;
    run_pass(0, 1, 0);

    // start pulses while busy must be dropped
    clear_board();
    mem[15] = 16'hFFFF; mem[10] = 16'h1234; mem[3] = 16'hFFFF;
    run_pass(0, 0, 1);

    // randomized boards and ready patterns
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 99) < 35) mem[i] = 16'hFFFF;
        else if ($urandom_range(0, 9) == 0) mem[i] = '0;
        else begin
          mem[i] = W'($urandom);
          if (mem[i] == 16'hFFFF) mem[i] = 16'hFFFE;
        end
      end
      run_pass(t % 3 != 0, 0, t % 5 == 0);
    end

    // reset during FILL aborts the pass
    for (int i = 0; i < 12; i++) mem[i] = 16'h0101 + W'(i);
    for (int i = 12; i < 16; i++) mem[i] = 16'hFFFF;
    mem_ready_li = 1'b1;
    start_li = 1'b1;
    @(posedge clk_li); #1;
    start_li = 1'b0;
    guard = 0;
    while (!(wr_v_lo && wr_data_lo == '0) && guard < 500) begin
      @(posedge clk_li); #1;
      guard++;
    end
    chk("reached_fill", wr_v_lo && wr_data_lo == '0, 1);
    reset_li = 1'b1;
    @(posedge clk_li); #1;
    reset_li = 1'b0;
    chk("abort_rd_v", rd_v_lo, 0);
    chk("abort_wr_v", wr_v_lo, 0);
    chk("abort_lines", lines_cleared_lo, 0);
    chk("abort_busy", busy_lo, 0);
    snap = total_writes();
    repeat (20) begin @(posedge clk_li); #1; end
    chk("abort_no_writes", total_writes(), snap);
    chk("abort_idle", busy_lo, 0);

    // recovery pass on the partially processed board
    run_pass(1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errors);
    $finish;
  end

endmodule
